// File: rtl/lsp_tdist_pkg.sv
// Shared constants and state encoding for the G.729 weighted LSP distortion block.
package lsp_tdist_pkg;
  localparam int M       = 10;
  localparam int SHIFT   = 4;
  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int SADDR_W = 11;
  localparam int CADDR_W = 12;
  localparam int IDX_W   = $clog2(M);

  typedef enum logic [2:0] {
    IDLE, RD_BUF, RD_RBUF, RD_WEGT, CALC, ACC, WRITE, DONE
  } state_t;
endpackage

// File: rtl/lsp_get_tdist_sat_ops.sv
// g729_sat_ops: combinational G.729 basic ops (sub, mult, L_mult, L_shl, L_mac)
// for one distortion element, with saturation indicators.
module g729_sat_ops
  import lsp_tdist_pkg::*;
(
  input  logic signed [DATA_W-1:0] buf_val,
  input  logic signed [DATA_W-1:0] rbuf_val,
  input  logic signed [DATA_W-1:0] fg_val,
  input  logic signed [DATA_W-1:0] wegt_val,
  input  logic signed [DATA_W-1:0] tmp_val,
  input  logic signed [ACC_W-1:0]  acc_val,
  output logic signed [DATA_W-1:0] tmp_next,
  output logic signed [ACC_W-1:0]  acc_next,
  output logic                     sat_tmp,
  output logic                     sat_acc
);
  function automatic logic signed [47:0] ext16(input logic signed [15:0] x);
    return {{32{x[15]}}, x};
  endfunction

  function automatic logic signed [47:0] ext32(input logic signed [31:0] x);
    return {{16{x[31]}}, x};
  endfunction

  function automatic logic ovf16(input logic signed [47:0] x);
    return (x > 48'sd32767) || (x < -48'sd32768);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [47:0] x);
    if (x > 48'sd32767)       return 16'sh7fff;
    else if (x < -48'sd32768) return 16'sh8000;
    else                      return x[15:0];
  endfunction

  function automatic logic ovf32(input logic signed [47:0] x);
    return (x > 48'sd2147483647) || (x < -48'sd2147483648);
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [47:0] x);
    if (x > 48'sd2147483647)       return 32'sh7fffffff;
    else if (x < -48'sd2147483648) return 32'sh80000000;
    else                           return x[31:0];
  endfunction

  logic signed [47:0] diff_w, mult_w, lmult_w, shl_w, mac_prod_w, mac_sum_w;
  logic signed [15:0] diff, hi;
  logic signed [31:0] lmult, shl, mac_prod;

  // All intermediates are 48-bit so every saturation test sees the exact value.
  always_comb begin
    diff_w     = ext16(buf_val) - ext16(rbuf_val);
    diff       = sat16(diff_w);
    mult_w     = (ext16(diff) * ext16(fg_val)) >>> 15;
    tmp_next   = sat16(mult_w);
    lmult_w    = (ext16(wegt_val) * ext16(tmp_val)) <<< 1;
    lmult      = sat32(lmult_w);
    shl_w      = ext32(lmult) <<< SHIFT;
    shl        = sat32(shl_w);
    hi         = shl[31:16];
    mac_prod_w = (ext16(hi) * ext16(tmp_val)) <<< 1;
    mac_prod   = sat32(mac_prod_w);
    mac_sum_w  = ext32(acc_val) + ext32(mac_prod);
    acc_next   = sat32(mac_sum_w);
    sat_tmp    = ovf16(diff_w) | ovf16(mult_w);
    sat_acc    = ovf32(lmult_w) | ovf32(shl_w) | ovf32(mac_prod_w) | ovf32(mac_sum_w);
  end
endmodule

// File: rtl/lsp_get_tdist.sv
// Weighted LSP distortion L_tdist for one MA mode, read element-serially from scratch/const memory.
// Optional sticky saturation flag output enabled by LSP_TDIST_OVERFLOW_FLAG_EN.
module lsp_get_tdist
  import lsp_tdist_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SADDR_W-1:0] bufAddr,
  input  logic [SADDR_W-1:0] rbufAddr,
  input  logic [SADDR_W-1:0] wegtAddr,
  input  logic [SADDR_W-1:0] tdistAddr,
  input  logic [CADDR_W-1:0] fgSumAddr,
  output logic [SADDR_W-1:0] memReadAddr,
  input  logic [31:0]        memIn,
  output logic [CADDR_W-1:0] constMemAddr,
  input  logic [31:0]        constMemIn,
  output logic               memWriteEn,
  output logic [SADDR_W-1:0] memWriteAddr,
  output logic [31:0]        memOut,
  output logic [31:0]        L_tdist,
  output logic               done
`ifdef LSP_TDIST_OVERFLOW_FLAG_EN
  ,
  output logic               overflow
`endif
);
  state_t state;
  logic [IDX_W-1:0]   j;
  logic [SADDR_W-1:0] buf_base, rbuf_base, wegt_base, tdist_base;
  logic [CADDR_W-1:0] fg_base;
  logic [SADDR_W-1:0] j_s;
  logic [CADDR_W-1:0] j_c;

  logic signed [DATA_W-1:0] buf_p0, rbuf_p0, fg_p0, wegt_p0;
  logic signed [DATA_W-1:0] tmp_p1, tmp_next;
  logic signed [ACC_W-1:0]  acc_p2, acc_next;
  logic                     sat_tmp, sat_acc;

  assign j_s = SADDR_W'(j);
  assign j_c = CADDR_W'(j);

  g729_sat_ops u_ops (
    .buf_val  (buf_p0),
    .rbuf_val (rbuf_p0),
    .fg_val   (fg_p0),
    .wegt_val (wegt_p0),
    .tmp_val  (tmp_p1),
    .acc_val  (acc_p2),
    .tmp_next (tmp_next),
    .acc_next (acc_next),
    .sat_tmp  (sat_tmp),
    .sat_acc  (sat_acc)
  );

`ifdef LSP_TDIST_OVERFLOW_FLAG_EN
  logic unused_hi;
  assign unused_hi = ^{memIn[31:16], constMemIn[31:16]};
`else
  logic unused_hi;
  assign unused_hi = ^{memIn[31:16], constMemIn[31:16], sat_tmp, sat_acc};
`endif

  // Addresses are registered one state ahead so they are stable in the state that issues the read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      memWriteEn   <= 1'b0;
      memReadAddr  <= '0;
      memWriteAddr <= '0;
      memOut       <= '0;
      constMemAddr <= '0;
      L_tdist      <= '0;
      acc_p2       <= '0;
      j            <= '0;
`ifdef LSP_TDIST_OVERFLOW_FLAG_EN
      overflow     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          memWriteEn <= 1'b0;
          if (start) begin
            buf_base     <= bufAddr;
            rbuf_base    <= rbufAddr;
            wegt_base    <= wegtAddr;
            tdist_base   <= tdistAddr;
            fg_base      <= fgSumAddr;
            acc_p2       <= '0;
            j            <= '0;
            memReadAddr  <= bufAddr;
            constMemAddr <= fgSumAddr;
`ifdef LSP_TDIST_OVERFLOW_FLAG_EN
            overflow     <= 1'b0;
`endif
            state        <= RD_BUF;
          end
        end
        RD_BUF: begin
          memReadAddr <= rbuf_base + j_s;
          state       <= RD_RBUF;
        end
        RD_RBUF: begin
          buf_p0      <= memIn[15:0];
          fg_p0       <= constMemIn[15:0];
          memReadAddr <= wegt_base + j_s;
          state       <= RD_WEGT;
        end
        RD_WEGT: begin
          rbuf_p0 <= memIn[15:0];
          state   <= CALC;
        end
        // ---- stage boundary: operands complete, tmp registered ----
        CALC: begin
          wegt_p0 <= memIn[15:0];
          tmp_p1  <= tmp_next;
`ifdef LSP_TDIST_OVERFLOW_FLAG_EN
          overflow <= overflow | sat_tmp;
`endif
          state   <= ACC;
        end
        // ---- stage boundary: weighted term folded into accumulator ----
        ACC: begin
          acc_p2 <= acc_next;
`ifdef LSP_TDIST_OVERFLOW_FLAG_EN
          overflow <= overflow | sat_acc;
`endif
          if (j == IDX_W'(M - 1)) begin
            memWriteEn   <= 1'b1;
            memWriteAddr <= tdist_base;
            memOut       <= acc_next;
            state        <= WRITE;
          end else begin
            j            <= j + IDX_W'(1);
            memReadAddr  <= buf_base + j_s + 11'd1;
            constMemAddr <= fg_base + j_c + 12'd1;
            state        <= RD_BUF;
          end
        end
        WRITE: begin
          memWriteEn <= 1'b0;
          L_tdist    <= acc_p2;
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsp_get_tdist.md
Name: lsp_get_tdist

Overview:
- Computes the G.729 weighted LSP distortion for one MA-predictor mode: L_tdist = sum over j = 0..M-1 of wegt[j]*tmp*tmp, where tmp = mult(sub(buf[j], rbuf[j]), fg_sum[j]).
- Sits directly downstream of lsp_select_2. It consumes the buf vector lsp_select_2 leaves in scratch memory and writes L_tdist back for the last-select stage.
- Reads its operands through one scratch-memory read port and the constant memory. All arithmetic is internal.

Parameters:
- M, 10, vector length (LSP order).
- SHIFT, 4, left shift that converts Q11 wegt products before extract_h.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin computation; sampled only in IDLE
- bufAddr  in  11  scratch base address of buf[0..M-1]
- rbufAddr  in  11  scratch base address of rbuf[0..M-1]
- wegtAddr  in  11  scratch base address of wegt[0..M-1] (Q11)
- tdistAddr  in  11  scratch address that receives the result
- fgSumAddr  in  12  constant-memory base address of fg_sum[mode][0..M-1]
- memReadAddr  out  11  scratch read address
- memIn  in  32  scratch read data; 1-cycle latency; operand is in bits [15:0]
- constMemAddr  out  12  constant-memory address
- constMemIn  in  32  constant read data; 1-cycle latency; operand is in bits [15:0]
- memWriteEn  out  1  scratch write strobe
- memWriteAddr  out  11  scratch write address
- memOut  out  32  scratch write data
- L_tdist  out  32  result; held until the next start
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE.
  - All outputs clear to 0: done, memWriteEn, memReadAddr, memWriteAddr, memOut, constMemAddr, L_tdist.
  - Accumulator and index j clear to 0.
  - Reset wins over every other event, including reset arriving mid-operation.
- Base addresses are latched when start is accepted. Element j is read at base+j. No wrap handling; callers keep the range in bounds.
- State machine, one element per 5 states:
  - IDLE: when start==1, latch the base addresses, set acc=0 and j=0, go to RD_BUF.
  - RD_BUF: drive memReadAddr=buf+j and constMemAddr=fgSum+j.
  - RD_RBUF: capture buf and fg from the read data. Drive rbuf+j.
  - RD_WEGT: capture rbuf. Drive wegt+j.
  - CALC: capture wegt. Register tmp = mult(sub(buf, rbuf), fg).
  - ACC:
    - acc = L_mac(acc, extract_h(L_shl(L_mult(wegt, tmp), SHIFT)), tmp).
    - If j==M-1, go to WRITE. Otherwise j++ and go to RD_BUF.
  - WRITE: memWriteEn=1, memWriteAddr=tdistAddr, memOut=acc. Load L_tdist=acc.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge 0. WRITE is in cycle 5M+1 = 51. done is high in cycle 52.
- start while not in IDLE is ignored. If start is held high, a new run begins on the cycle after DONE.
- memWriteEn is high only in WRITE.
- Arithmetic is G.729 basic-op exact:
  - sub: 16-bit saturating.
  - mult: sat16((a*b)>>15); -32768*-32768 gives 32767.
  - L_mult: sat32(2*a*b).
  - L_shl: saturating.
  - extract_h: bits [31:16].
  - L_mac: sat32(acc + L_mult(a,b)).

Optional Feature:
- Macro LSP_TDIST_OVERFLOW_FLAG_EN.
- Defined: adds output port overflow (1 bit).
  - Sticky-set whenever any sub, mult, L_mult, L_shl or L_mac saturates during a run.
  - Cleared at start acceptance and on reset.
  - Valid from done onward.
- Undefined: the port and its logic are absent. Arithmetic results are identical either way.

Decomposition:
- Shared package lsp_tdist_pkg:
  - M and SHIFT.
  - State encoding constants: IDLE, RD_BUF, RD_RBUF, RD_WEGT, CALC, ACC, WRITE, DONE.
  - Address widths: 11 for scratch, 12 for constant memory.
- One sub-module, g729_sat_ops: purely combinational sub/mult/L_mult/L_shl/L_mac with saturation-indicator outputs. The FSM and registers live in lsp_get_tdist.

Test Plan:
1. buf[j]==rbuf[j] for all j, any fg/wegt → L_tdist=0x00000000; write of 0 to tdistAddr in cycle 51; done pulse in cycle 52 only.
2. buf=0x1000, rbuf=0, fg=0x4000, wegt=0x0800 for all j → tmp=2048, per-element term 0x00800000, L_tdist=0x05000000.
3. buf=0x7FFF, rbuf=0x8000, fg=0x7FFF, wegt=0x7FFF → sub saturates to 0x7FFF, tmp=0x7FFE, acc saturates at element 1, L_tdist=0x7FFFFFFF; overflow=1 with the macro defined.
4. Run scenario 2, drive reset=0 at cycle 20 → next cycle all outputs 0 and state IDLE, no write occurs. Restart → L_tdist=0x05000000.
5. Pulse start again at cycles 5 and 30 during a run → ignored; single write and single done; result unchanged.
6. Hold start=1 continuously with different base addresses per run → back-to-back runs. Each run's first read occurs the cycle after DONE. Each run's addresses are those latched at its own start.
